// File: rtl/gray_seq_ctrl.sv
// -----------------------------------------------------------------------------
// gray_seq_ctrl
//
// Run controller for a gray-coded counter. A run loads a binary start value,
// then steps the count up or down once per cycle for a programmed number of
// steps. Each step updates the registered binary count and its gray code on
// the same edge and raises a one-cycle strobe in the following cycle. Runs
// can be paused (hold), terminated early (abort) and signal normal completion
// with a one-cycle done pulse.
//
// Optional build macro: GRAY_SEQ_CHECK_EN
//   Defined   : a registered checker watches every step and raises the sticky
//               seq_err flag if gray_out moved by other than exactly one bit,
//               or if gray_out disagrees with bin_out ^ (bin_out >> 1).
//   Undefined : checker absent, seq_err tied low. Port list is identical.
//
// Parameters
//   WIDTH  counter width in bits (count space 2^WIDTH)
//   LEN_W  width of the run-length field
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run request; accepted only in IDLE
//   start_val  in   binary start value, sampled with an accepted start
//   len        in   number of steps, sampled with an accepted start
//   dir        in   0 = count up, 1 = count down, sampled with an accepted start
//   hold       in   level; pauses stepping
//   abort      in   terminate the run early (ignored in IDLE)
//   bin_out    out  registered binary count
//   gray_out   out  registered gray code of bin_out
//   step_valid out  high for one cycle after each step
//   wrap       out  high with step_valid when that step wrapped
//   busy       out  high whenever the controller is not IDLE
//   done       out  one-cycle pulse on normal completion
//   seq_err    out  sticky step checker flag
//   dbg_state  out  current FSM state encoding (debug observation only)
//
// Handshake: start is a request level sampled on each rising edge. It is
// accepted on an edge where the controller is IDLE (busy low); at any other
// time it is dropped, never queued. The caller should treat busy going high
// as the acknowledgement and hold start for one cycle only.
// -----------------------------------------------------------------------------
module gray_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [LEN_W-1:0] len,
    input  logic             dir,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             step_valid,
    output logic             wrap,
    output logic             busy,
    output logic             done,
    output logic             seq_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [LEN_W-1:0] r_remaining;
    logic             r_dir;
    logic             r_step_valid;
    logic             r_wrap;

    logic             w_load;
    logic             w_step;
    logic             w_last_step;
    logic             w_wrap;
    logic [WIDTH-1:0] w_bin_step;
    logic [WIDTH-1:0] w_bin_next;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_last_step = (r_remaining == LEN_W'(1));

    // -------------------------------------------------------------------------
    // FSM: next state and datapath controls
    // Priority in RUN is abort > hold > step. Leaving HOLD never steps on the
    // same edge, which gives the one-cycle resume bubble.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // abort is deliberately not looked at here: start wins.
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (hold) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_step = 1'b1;
                    if (w_last_step) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (!hold) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Count datapath
    // -------------------------------------------------------------------------
    assign w_bin_step = r_dir ? (r_bin - WIDTH'(1)) : (r_bin + WIDTH'(1));
    assign w_bin_next = w_load ? start_val : (w_step ? w_bin_step : r_bin);

    // Wrap is judged on the pre-step value: all-ones going up, zero going down.
    assign w_wrap = w_step & (r_dir ? (r_bin == '0) : (r_bin == '1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin        <= '0;
            r_gray       <= '0;
            r_remaining  <= '0;
            r_dir        <= 1'b0;
            r_step_valid <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_bin        <= w_bin_next;
            // Gray is derived from the next binary value so both registers
            // change on the same edge.
            r_gray       <= w_bin_next ^ (w_bin_next >> 1);
            r_step_valid <= w_step;
            r_wrap       <= w_wrap;
            if (w_load) begin
                r_remaining <= len;
                r_dir       <= dir;
            end else if (w_step) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional step checker
    // -------------------------------------------------------------------------
`ifdef GRAY_SEQ_CHECK_EN
    logic [WIDTH-1:0] r_prev_gray;
    logic             r_chk_pending;
    logic             r_seq_err;
    logic [WIDTH-1:0] w_gray_diff;
    logic             w_one_bit;
    logic             w_gray_bad;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign w_gray_diff = r_prev_gray ^ r_gray;
    assign w_one_bit   = (w_gray_diff != '0) &&
                         ((w_gray_diff & (w_gray_diff - WIDTH'(1))) == '0);
    assign w_gray_bad  = (r_gray != (r_bin ^ (r_bin >> 1)));

    // The pre-step gray value is captured on the stepping edge and compared
    // against the post-step value in the following cycle, so seq_err sets
    // one cycle after the offending step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_gray   <= '0;
            r_chk_pending <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_chk_pending <= w_step;
            if (w_step) begin
                r_prev_gray <= r_gray;
            end
            if (w_load) begin
                r_seq_err <= 1'b0;
            end else if (r_chk_pending && (!w_one_bit || w_gray_bad)) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign seq_err = r_seq_err;
`else
    assign seq_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bin_out    = r_bin;
    assign gray_out   = r_gray;
    assign step_valid = r_step_valid;
    assign wrap       = r_wrap;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for gray_seq_ctrl (WIDTH=4, LEN_W=8).
// Expected steps {wrap, gray, bin} are queued before each run is started and
// popped by the monitor whenever step_valid is seen. Per-run statistics
// (busy cycles, done pulses, done coincident with a step) are compared when
// the run has returned to IDLE.
// Handshake: start is a one-cycle request driven on the falling edge; it is
// accepted by the DUT on the next rising edge only if busy is low.
// -----------------------------------------------------------------------------
module tb_gray_seq_ctrl;
  localparam int W  = 4;
  localparam int LW = 8;
  localparam int EW = 2 * W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start;
  logic [W-1:0]  start_val;
  logic [LW-1:0] len;
  logic          dir;
  logic          hold;
  logic          abort;
  logic [W-1:0]  bin_out;
  logic [W-1:0]  gray_out;
  logic          step_valid;
  logic          wrap;
  logic          busy;
  logic          done;
  logic          seq_err;
  logic [1:0]    dbg_state;

  gray_seq_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_val  (start_val),
    .len        (len),
    .dir        (dir),
    .hold       (hold),
    .abort      (abort),
    .bin_out    (bin_out),
    .gray_out   (gray_out),
    .step_valid (step_valid),
    .wrap       (wrap),
    .busy       (busy),
    .done       (done),
    .seq_err    (seq_err),
    .dbg_state  (dbg_state)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int done_with_step = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_step(input logic [W-1:0] b, input logic [W-1:0] g, input logic w);
    exp_q.push_back({w, g, b});
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (step_valid === 1'b1) done_with_step++;
      end
      if (step_valid === 1'b1) begin
        check("step_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("step_bin",  32'(bin_out),  32'(exp_e[W-1:0]));
          check("step_gray", 32'(gray_out), 32'(exp_e[2*W-1:W]));
          check("step_wrap", 32'(wrap),     32'(exp_e[2*W]));
        end
      end else if (wrap !== 1'b0) begin
        check("wrap_without_step", 32'(wrap), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic clr_stats();
    done_cnt       = 0;
    busy_cnt       = 0;
    done_with_step = 0;
  endtask

  // Returns on the falling edge right after the accepting edge. The sampled
  // fields are then scrambled to show they are not re-sampled mid-run.
  task automatic do_start(input logic [W-1:0] sv, input logic [LW-1:0] l, input logic d);
    @(negedge clk);
    start     = 1'b1;
    start_val = sv;
    len       = l;
    dir       = d;
    @(negedge clk);
    start     = 1'b0;
    start_val = W'($urandom_range(0, 15));
    len       = LW'($urandom_range(0, 255));
    dir       = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_in_time"}, 32'(busy), 32'd0);
    #2;
  endtask

  task automatic end_checks(input string tag, input int exp_done, input int exp_busy,
                            input int exp_dws);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_cnt"}, done_cnt, exp_done);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_done_with_step"}, done_with_step, exp_dws);
    check({tag, "_seq_err"}, 32'(seq_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    start_val = '0;
    len       = '0;
    dir       = 1'b0;
    hold      = 1'b0;
    abort     = 1'b0;

    // reset state
    #1;
    check("reset_bin",   32'(bin_out),    32'd0);
    check("reset_gray",  32'(gray_out),   32'd0);
    check("reset_busy",  32'(busy),       32'd0);
    check("reset_step",  32'(step_valid), 32'd0);
    check("reset_done",  32'(done),       32'd0);
    check("reset_seqerr", 32'(seq_err),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // up run: 0 -> 5
    clr_stats();
    push_step(4'd1, 4'b0001, 1'b0);
    push_step(4'd2, 4'b0011, 1'b0);
    push_step(4'd3, 4'b0010, 1'b0);
    push_step(4'd4, 4'b0110, 1'b0);
    push_step(4'd5, 4'b0111, 1'b0);
    do_start(4'd0, 8'd5, 1'b0);
    wait_idle("up");
    end_checks("up", 1, 6, 1);

    // wrap up: 14 -> 15, 0, 1
    clr_stats();
    push_step(4'd15, 4'b1000, 1'b0);
    push_step(4'd0,  4'b0000, 1'b1);
    push_step(4'd1,  4'b0001, 1'b0);
    do_start(4'd14, 8'd3, 1'b0);
    check("load_bin",  32'(bin_out),  32'd14);
    check("load_gray", 32'(gray_out), 32'b1001);
    wait_idle("wrap_up");
    end_checks("wrap_up", 1, 4, 1);

    // wrap down: 1 -> 0, 15
    clr_stats();
    push_step(4'd0,  4'b0000, 1'b0);
    push_step(4'd15, 4'b1000, 1'b1);
    do_start(4'd1, 8'd2, 1'b1);
    wait_idle("wrap_dn");
    end_checks("wrap_dn", 1, 3, 1);

    // hold for 3 edges after step 2, then one bubble
    clr_stats();
    push_step(4'd1, 4'b0001, 1'b0);
    push_step(4'd2, 4'b0011, 1'b0);
    push_step(4'd3, 4'b0010, 1'b0);
    push_step(4'd4, 4'b0110, 1'b0);
    push_step(4'd5, 4'b0111, 1'b0);
    push_step(4'd6, 4'b0101, 1'b0);
    do_start(4'd0, 8'd6, 1'b0);
    repeat (2) @(negedge clk);
    hold = 1'b1;
    repeat (3) @(negedge clk);
    hold = 1'b0;
    wait_idle("hold");
    end_checks("hold", 1, 11, 1);
    check("hold_final_bin", 32'(bin_out), 32'd6);

    // abort after step 3
    clr_stats();
    push_step(4'd1, 4'b0001, 1'b0);
    push_step(4'd2, 4'b0011, 1'b0);
    push_step(4'd3, 4'b0010, 1'b0);
    do_start(4'd0, 8'd6, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_next", 32'(busy), 32'd0);
    check("abort_bin_kept", 32'(bin_out), 32'd3);
    wait_idle("abort");
    end_checks("abort", 0, 4, 0);

    // abort while in HOLD after step 1
    clr_stats();
    push_step(4'd1, 4'b0001, 1'b0);
    do_start(4'd0, 8'd6, 1'b0);
    @(negedge clk);
    hold = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    hold  = 1'b0;
    check("hold_abort_bin", 32'(bin_out), 32'd1);
    wait_idle("hold_abort");
    end_checks("hold_abort", 0, 4, 0);

    // zero length: done only
    clr_stats();
    do_start(4'd5, 8'd0, 1'b0);
    check("zero_done_next", 32'(done), 32'd1);
    wait_idle("zero");
    end_checks("zero", 1, 1, 0);
    check("zero_bin",  32'(bin_out),  32'd5);
    check("zero_gray", 32'(gray_out), 32'b0111);

    // start during RUN is ignored
    clr_stats();
    push_step(4'd1, 4'b0001, 1'b0);
    push_step(4'd2, 4'b0011, 1'b0);
    push_step(4'd3, 4'b0010, 1'b0);
    push_step(4'd4, 4'b0110, 1'b0);
    do_start(4'd0, 8'd4, 1'b0);
    start     = 1'b1;
    start_val = 4'd9;
    len       = 8'd1;
    dir       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    end_checks("busy_start", 1, 5, 1);
    check("busy_start_bin", 32'(bin_out), 32'd4);

    // start and abort together in IDLE: start wins
    clr_stats();
    push_step(4'd3, 4'b0010, 1'b0);
    abort = 1'b1;
    do_start(4'd2, 8'd1, 1'b0);
    abort = 1'b0;
    wait_idle("start_abort");
    end_checks("start_abort", 1, 2, 1);

    // reset asserted mid-run
    clr_stats();
    push_step(4'd1, 4'b0001, 1'b0);
    push_step(4'd2, 4'b0011, 1'b0);
    do_start(4'd0, 8'd8, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_bin",  32'(bin_out),    32'd0);
    check("midrst_gray", 32'(gray_out),   32'd0);
    check("midrst_busy", 32'(busy),       32'd0);
    check("midrst_step", 32'(step_valid), 32'd0);
    check("midrst_done", 32'(done),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    end_checks("midrst", 0, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_seq_ctrl.md
Name: gray_seq_ctrl

Overview:
- Run controller for a gray-coded counter.
- Each run loads a binary start value and steps the count up or down for a programmed number of steps, emitting registered gray code and a strobe per step.
- Supports hold, abort and a done pulse.
- Sits between a control FSM or CPU register block and any consumer of gray-coded positions, such as encoder emulation or pointer sequencing.

Parameters:
- WIDTH, 4, counter width in bits; count space is 2^WIDTH.
- LEN_W, 8, width of the run-length field.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a run; accepted only in IDLE.
- start_val  input  WIDTH  binary start value, sampled with an accepted start.
- len  input  LEN_W  number of steps, sampled with an accepted start.
- dir  input  1  0 = count up, 1 = count down; sampled with an accepted start.
- hold  input  1  level; pauses stepping.
- abort  input  1  terminate the run early.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered gray code, equal to bin_out ^ (bin_out >> 1).
- step_valid  output  1  high for one cycle after each step.
- wrap  output  1  high with step_valid when that step wrapped.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse on normal completion.
- seq_err  output  1  sticky checker flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bin_out=0; gray_out=0; remaining=0; step_valid, wrap, done, seq_err all 0.
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - start=1 latches start_val into the count, with gray_out updated on the same edge.
  - Also latches len into remaining and latches dir.
  - Next state is RUN if len != 0, else DONE (zero-length run: no steps, done still pulses).
- RUN, priority abort > hold > step:
  - abort=1: go to IDLE, count retained, no done.
  - hold=1: go to HOLD, no step this edge.
  - Otherwise step: count += 1 (dir=0) or -= 1 (dir=1), modulo 2^WIDTH; gray_out updated on the same edge; remaining -= 1.
  - If remaining was 1, go to DONE.
- HOLD:
  - abort=1: go to IDLE.
  - hold=0: go to RUN with no step on that edge (one-cycle resume bubble).
  - hold=1: stay in HOLD.
- DONE: go to IDLE after one cycle; done=1 while in DONE.
- Timing for start sampled at edge 0 with len=N and no hold:
  - Steps occur at edges 1..N.
  - done is high in the cycle after edge N, concurrent with the last step_valid.
  - busy is high from after edge 0 through the cycle after edge N; IDLE after edge N+1.
- step_valid and wrap are registered, high in the cycle following the stepping edge.
- wrap conditions: up 2^WIDTH-1 -> 0; down 0 -> 2^WIDTH-1.
- A new start is ignored in RUN, HOLD and DONE (no queueing). start and abort together in IDLE: start wins; abort is ignored in IDLE.
- start_val, len and dir are not re-sampled during a run.
- Each step changes exactly one bit of gray_out.
- Reset asserted mid-run returns to the reset state immediately; no done.

Optional Feature:
- Macro: GRAY_SEQ_CHECK_EN.
- Defined:
  - A registered checker compares gray_out before and after every step.
  - If the Hamming distance is not exactly 1, or gray_out != bin_out ^ (bin_out >> 1), seq_err sets one cycle after the offending step.
  - seq_err is sticky; cleared by reset or an accepted start.
- Undefined: checker logic is absent; seq_err is tied to 0. The port list is unchanged.

Test Plan:
- Reset: assert rst_n=0 mid-run → bin_out=0, gray_out=0, busy=0, step_valid=0, done=0 immediately (async).
- Up run (WIDTH=4): start_val=0, len=5, dir=0 → gray_out sequence 0001, 0011, 0010, 0110, 0111.
  - Five step_valid pulses; done concurrent with the 5th.
  - busy high for 6 cycles; wrap never set.
- Wrap up: start_val=14, len=3, dir=0 → bin 15, 0, 1; gray 1000, 0000, 0001; wrap only with bin 0.
- Wrap down: start_val=1, len=2, dir=1 → bin 0, 15; gray 0000, 1000; wrap with bin 15.
- Hold and abort: len=6 with hold high for 3 cycles after step 2 → no steps during hold, one bubble after release, total 6 steps, done once.
  - Repeat with abort after step 3 → IDLE next cycle, bin_out holds step-3 value, no done.
- Zero length and busy start: len=0 → no step_valid, done pulses 1 cycle after start.
  - start pulsed during RUN → ignored; run length unchanged.
  - With GRAY_SEQ_CHECK_EN defined, seq_err stays 0 throughout all scenarios.
